// File: rtl/imem_access_ctrl.sv
`default_nettype none
//==============================================================================
// Module      : imem_access_ctrl
// Description : Sequences a single-port, byte-wide, big-endian instruction
//               memory shared between the CPU fetch path (32-bit word reads)
//               and the program loader (single-byte writes). A fetch issues
//               four sequential byte reads and assembles them into one word,
//               first byte in the most significant position.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
// Ports:
//   CLK, Reset                    clock (rising edge), synchronous active-high reset
//   FetchReq/FetchAddr/FetchRdy   fetch handshake; address captured at accept
//   FetchValid/FetchData/FetchErr one-cycle result pulse, data and error flag
//   LoadReq/LoadAddr/LoadByte     loader byte-write request
//   LoadRdy/LoadDone/LoadErr      loader handshake, completion pulse and error
//   MemAddr/MemRW/MemWE/MemWData  memory command (registered)
//   MemRData                      memory read byte, one cycle after MemRW
//
// Optional feature macro: IMEM_LASTWORD_CACHE_EN
//   When defined, the last successfully fetched word is held with its address
//   and returned without a memory access on a repeated fetch of that address.
//==============================================================================
module imem_access_ctrl #(
   parameter int MEM_BYTES = 128,
   parameter int ADDR_W    = 32
) (
   input  logic              CLK,
   input  logic              Reset,
   input  logic              FetchReq,
   input  logic [ADDR_W-1:0] FetchAddr,
   output logic              FetchRdy,
   output logic              FetchValid,
   output logic [31:0]       FetchData,
   output logic              FetchErr,
   input  logic              LoadReq,
   input  logic [ADDR_W-1:0] LoadAddr,
   input  logic [7:0]        LoadByte,
   output logic              LoadRdy,
   output logic              LoadDone,
   output logic              LoadErr,
   output logic [ADDR_W-1:0] MemAddr,
   output logic              MemRW,
   output logic              MemWE,
   output logic [7:0]        MemWData,
   input  logic [7:0]        MemRData
);

   localparam logic [ADDR_W-1:0] c_MEM_BYTES = ADDR_W'(MEM_BYTES);
   localparam logic [ADDR_W-1:0] c_LAST_WORD = ADDR_W'(MEM_BYTES - 4);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RD    = 2'd1,
      S_DRAIN = 2'd2,
      S_WR    = 2'd3
   } state_t;

   state_t            r_state,   w_state_n;
   logic [1:0]        r_cnt,     w_cnt_n;
   logic [ADDR_W-1:0] r_addr,    w_addr_n;
   logic [23:0]       r_shift,   w_shift_n;
   logic [31:0]       r_fdata,   w_fdata_n;
   logic              r_fvalid,  w_fvalid_n;
   logic              r_ferr,    w_ferr_n;
   logic              r_ldone,   w_ldone_n;
   logic              r_lerr,    w_lerr_n;
   logic [ADDR_W-1:0] r_memaddr, w_memaddr_n;
   logic              r_memrw,   w_memrw_n;
   logic              r_memwe,   w_memwe_n;
   logic [7:0]        r_wdata,   w_wdata_n;
   // Set when the most recent grant went to fetch; cleared at reset so that
   // fetch wins the first contested arbitration.
   logic              r_last_fetch, w_last_fetch_n;

`ifdef IMEM_LASTWORD_CACHE_EN
   logic              r_cvalid, w_cvalid_n;
   logic [ADDR_W-1:0] r_tag,    w_tag_n;
   logic [31:0]       r_cdata,  w_cdata_n;
`endif

   logic              w_idle;
   logic              w_fetch_go;
   logic              w_load_go;
   logic              w_fetch_bad;
   logic              w_load_bad;
   logic [1:0]        w_cnt_inc;

   assign w_idle      = (r_state == S_IDLE);
   // Fetch wins unless the loader is also requesting and fetch had the last grant.
   assign w_fetch_go  = w_idle && FetchReq && !(LoadReq && r_last_fetch);
   assign w_load_go   = w_idle && LoadReq && !w_fetch_go;
   // Range check on the unincremented address, so A+1..A+3 never wrap.
   assign w_fetch_bad = (FetchAddr[1:0] != 2'b00) || (FetchAddr > c_LAST_WORD);
   assign w_load_bad  = (LoadAddr >= c_MEM_BYTES);
   assign w_cnt_inc   = r_cnt + 2'd1;

   always_comb begin
      w_state_n      = r_state;
      w_cnt_n        = r_cnt;
      w_addr_n       = r_addr;
      w_shift_n      = r_shift;
      w_fdata_n      = r_fdata;
      w_fvalid_n     = 1'b0;
      w_ferr_n       = 1'b0;
      w_ldone_n      = 1'b0;
      w_lerr_n       = 1'b0;
      w_memaddr_n    = r_memaddr;
      w_memrw_n      = 1'b0;
      w_memwe_n      = 1'b0;
      w_wdata_n      = r_wdata;
      w_last_fetch_n = r_last_fetch;
`ifdef IMEM_LASTWORD_CACHE_EN
      w_cvalid_n     = r_cvalid;
      w_tag_n        = r_tag;
      w_cdata_n      = r_cdata;
`endif

      unique case (r_state)
         S_IDLE: begin
            if (w_fetch_go) begin
               w_last_fetch_n = 1'b1;
               if (w_fetch_bad) begin
                  w_fvalid_n = 1'b1;
                  w_ferr_n   = 1'b1;
                  w_fdata_n  = 32'd0;
               end
`ifdef IMEM_LASTWORD_CACHE_EN
               else if (r_cvalid && (FetchAddr == r_tag)) begin
                  w_fvalid_n = 1'b1;
                  w_fdata_n  = r_cdata;
               end
`endif
               else begin
                  w_state_n   = S_RD;
                  w_cnt_n     = 2'd0;
                  w_addr_n    = FetchAddr;
                  w_memaddr_n = FetchAddr;
                  w_memrw_n   = 1'b1;
               end
            end else if (w_load_go) begin
               w_last_fetch_n = 1'b0;
`ifdef IMEM_LASTWORD_CACHE_EN
               // Any load touching the cached word invalidates it, even one
               // whose write is suppressed.
               if (LoadAddr[ADDR_W-1:2] == r_tag[ADDR_W-1:2]) begin
                  w_cvalid_n = 1'b0;
               end
`endif
               if (w_load_bad) begin
                  w_ldone_n = 1'b1;
                  w_lerr_n  = 1'b1;
               end else begin
                  w_state_n   = S_WR;
                  w_memaddr_n = LoadAddr;
                  w_memwe_n   = 1'b1;
                  w_wdata_n   = LoadByte;
               end
            end
         end

         S_RD: begin
            // r_cnt is the offset of the read currently on the bus; the byte
            // returned now belongs to the previous offset.
            if (r_cnt != 2'd0) begin
               w_shift_n = {r_shift[15:0], MemRData};
            end
            if (r_cnt != 2'd3) begin
               w_memrw_n   = 1'b1;
               w_memaddr_n = r_addr + {{(ADDR_W-2){1'b0}}, w_cnt_inc};
               w_cnt_n     = w_cnt_inc;
            end else begin
               w_state_n = S_DRAIN;
            end
         end

         S_DRAIN: begin
            // Last byte (A+3) arrives this cycle.
            w_fdata_n  = {r_shift, MemRData};
            w_fvalid_n = 1'b1;
            w_state_n  = S_IDLE;
`ifdef IMEM_LASTWORD_CACHE_EN
            w_cvalid_n = 1'b1;
            w_tag_n    = r_addr;
            w_cdata_n  = {r_shift, MemRData};
`endif
         end

         S_WR: begin
            w_ldone_n = 1'b1;
            w_state_n = S_IDLE;
         end

         default: begin
            w_state_n = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge CLK) begin
      if (Reset) begin
         r_state      <= S_IDLE;
         r_cnt        <= 2'd0;
         r_addr       <= '0;
         r_shift      <= 24'd0;
         r_fdata      <= 32'd0;
         r_fvalid     <= 1'b0;
         r_ferr       <= 1'b0;
         r_ldone      <= 1'b0;
         r_lerr       <= 1'b0;
         r_memaddr    <= '0;
         r_memrw      <= 1'b0;
         r_memwe      <= 1'b0;
         r_wdata      <= 8'd0;
         r_last_fetch <= 1'b0;
`ifdef IMEM_LASTWORD_CACHE_EN
         r_cvalid     <= 1'b0;
         r_tag        <= '0;
         r_cdata      <= 32'd0;
`endif
      end else begin
         r_state      <= w_state_n;
         r_cnt        <= w_cnt_n;
         r_addr       <= w_addr_n;
         r_shift      <= w_shift_n;
         r_fdata      <= w_fdata_n;
         r_fvalid     <= w_fvalid_n;
         r_ferr       <= w_ferr_n;
         r_ldone      <= w_ldone_n;
         r_lerr       <= w_lerr_n;
         r_memaddr    <= w_memaddr_n;
         r_memrw      <= w_memrw_n;
         r_memwe      <= w_memwe_n;
         r_wdata      <= w_wdata_n;
         r_last_fetch <= w_last_fetch_n;
`ifdef IMEM_LASTWORD_CACHE_EN
         r_cvalid     <= w_cvalid_n;
         r_tag        <= w_tag_n;
         r_cdata      <= w_cdata_n;
`endif
      end
   end

   assign FetchRdy   = w_idle;
   assign LoadRdy    = w_idle;
   assign FetchValid = r_fvalid;
   assign FetchData  = r_fdata;
   assign FetchErr   = r_ferr;
   assign LoadDone   = r_ldone;
   assign LoadErr    = r_lerr;
   assign MemAddr    = r_memaddr;
   assign MemRW      = r_memrw;
   assign MemWE      = r_memwe;
   assign MemWData   = r_wdata;

endmodule
`default_nettype wire

// File: tb/tb_imem_access_ctrl.sv
`default_nettype none
//==============================================================================
// Module      : tb_imem_access_ctrl
// Description : Self-checking bench for imem_access_ctrl. A byte-array memory
//               with synchronous read sits behind the DUT; a separate reference
//               image of the memory and of the last-word cache decides every
//               expected value.
// Revision    : 1.0 - initial release
//==============================================================================
module tb_imem_access_ctrl;

`ifdef IMEM_LASTWORD_CACHE_EN
   localparam bit CACHE = 1'b1;
`else
   localparam bit CACHE = 1'b0;
`endif

   logic        CLK = 1'b0;
   logic        Reset;
   logic        FetchReq;
   logic [31:0] FetchAddr;
   logic        FetchRdy, FetchValid, FetchErr;
   logic [31:0] FetchData;
   logic        LoadReq;
   logic [31:0] LoadAddr;
   logic [7:0]  LoadByte;
   logic        LoadRdy, LoadDone, LoadErr;
   logic [31:0] MemAddr;
   logic        MemRW, MemWE;
   logic [7:0]  MemWData;
   logic [7:0]  MemRData;

   imem_access_ctrl #(.MEM_BYTES(128), .ADDR_W(32)) dut (
      .CLK(CLK), .Reset(Reset),
      .FetchReq(FetchReq), .FetchAddr(FetchAddr), .FetchRdy(FetchRdy),
      .FetchValid(FetchValid), .FetchData(FetchData), .FetchErr(FetchErr),
      .LoadReq(LoadReq), .LoadAddr(LoadAddr), .LoadByte(LoadByte),
      .LoadRdy(LoadRdy), .LoadDone(LoadDone), .LoadErr(LoadErr),
      .MemAddr(MemAddr), .MemRW(MemRW), .MemWE(MemWE),
      .MemWData(MemWData), .MemRData(MemRData)
   );

   always #5 CLK = ~CLK;

   // Instruction byte array, synchronous read.
   logic [7:0] mem [128];
   always @(posedge CLK) begin
      if (MemWE && (MemAddr < 32'd128)) mem[MemAddr[6:0]] <= MemWData;
      if (MemRW) MemRData <= (MemAddr < 32'd128) ? mem[MemAddr[6:0]] : 8'hEE;
   end

   // Reference model state.
   logic [7:0]  ref_mem [128];
   bit          ref_cv;
   logic [31:0] ref_tag;

   int checks = 0;
   int passes = 0;
   int fails  = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) passes++;
      else begin
         fails++;
         $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic do_load(input logic [31:0] a, input logic [7:0] b);
      bit err;
      err = (a >= 32'd128);
      chk("load_rdy", LoadRdy, 1);
      LoadReq = 1'b1; LoadAddr = a; LoadByte = b;
      tick();
      LoadReq = 1'b0; LoadAddr = $urandom; LoadByte = 8'($urandom);
      if (ref_cv && (a[31:2] == ref_tag[31:2])) ref_cv = 1'b0;
      if (err) begin
         chk("lderr_we",   MemWE, 0);
         chk("lderr_done", LoadDone, 1);
         chk("lderr_err",  LoadErr, 1);
         tick();
         chk("lderr_pulse", LoadDone, 0);
         chk("lderr_we2",   MemWE, 0);
      end else begin
         chk("ld_we",    MemWE, 1);
         chk("ld_addr",  MemAddr, a);
         chk("ld_wdata", MemWData, b);
         chk("ld_rw",    MemRW, 0);
         chk("ld_early", LoadDone, 0);
         tick();
         chk("ld_done",  LoadDone, 1);
         chk("ld_err",   LoadErr, 0);
         chk("ld_we_off", MemWE, 0);
         ref_mem[a[6:0]] = b;
      end
   endtask

   task automatic do_fetch(input logic [31:0] a);
      bit          err, hit;
      logic [31:0] exp;
      int          ia;
      err = (a[1:0] != 2'b00) || (a > 32'd124);
      hit = CACHE && ref_cv && (a == ref_tag) && !err;
      ia  = int'(a[6:0]);
      exp = err ? 32'd0 : {ref_mem[ia], ref_mem[ia+1], ref_mem[ia+2], ref_mem[ia+3]};
      chk("fetch_rdy", FetchRdy, 1);
      FetchReq = 1'b1; FetchAddr = a;
      tick();
      FetchReq = 1'b0; FetchAddr = $urandom;
      if (err || hit) begin
         chk("f1_valid", FetchValid, 1);
         chk("f1_err",   FetchErr, err);
         chk("f1_data",  FetchData, exp);
         chk("f1_rw",    MemRW, 0);
      end else begin
         for (int k = 0; k < 4; k++) begin
            chk("f_rw",    MemRW, 1);
            chk("f_addr",  MemAddr, a + 32'(k));
            chk("f_we",    MemWE, 0);
            chk("f_early", FetchValid, 0);
            tick();
         end
         chk("f_c5_rw",    MemRW, 0);
         chk("f_c5_valid", FetchValid, 0);
         tick();
         chk("f_valid", FetchValid, 1);
         chk("f_err",   FetchErr, 0);
         chk("f_data",  FetchData, exp);
         chk("f_rdy",   FetchRdy, 1);
         ref_cv  = CACHE;
         ref_tag = a;
      end
      tick();
      chk("f_pulse", FetchValid, 0);
      chk("f_hold",  FetchData, exp);
      chk("f_idle_rw", MemRW, 0);
   endtask

   initial begin
      logic [31:0] a, last_fa;
      logic [7:0]  b;
      int          r, grants;
      bit          rdy_before, got_f, exp_f;

      Reset = 1'b1; FetchReq = 1'b0; FetchAddr = '0;
      LoadReq = 1'b0; LoadAddr = '0; LoadByte = '0;
      ref_cv = 1'b0; ref_tag = '0;
      tick(); tick();
      chk("rst_fvalid", FetchValid, 0);
      chk("rst_ferr",   FetchErr, 0);
      chk("rst_ldone",  LoadDone, 0);
      chk("rst_lerr",   LoadErr, 0);
      chk("rst_rw",     MemRW, 0);
      chk("rst_we",     MemWE, 0);
      chk("rst_fdata",  FetchData, 0);
      chk("rst_maddr",  MemAddr, 0);
      chk("rst_wdata",  MemWData, 0);
      chk("rst_frdy",   FetchRdy, 1);
      chk("rst_lrdy",   LoadRdy, 1);
      Reset = 1'b0;
      tick();

      // Fill the whole memory through the loader.
      for (int i = 0; i < 128; i++) do_load(32'(i), 8'($urandom));

      // Directed word at 0.
      do_load(32'h0, 8'h04); do_load(32'h1, 8'h01);
      do_load(32'h2, 8'h00); do_load(32'h3, 8'h08);
      do_fetch(32'h0);
      chk("plan_word0", FetchData, 32'h04010008);
      do_fetch(32'h0);
      chk("plan_word0_again", FetchData, 32'h04010008);
      do_load(32'h2, 8'h5A);
      do_fetch(32'h0);
      chk("plan_word0_new", FetchData, 32'h04015A08);

      // Error and boundary fetches.
      do_fetch(32'h6);
      do_fetch(32'h7C);
      do_fetch(32'h80);
      do_fetch(32'h7F);
      do_fetch(32'hFFFF_FFFC);

      // Load-then-fetch word.
      do_load(32'h10, 8'hAB); do_load(32'h11, 8'hCD);
      do_load(32'h12, 8'hEF); do_load(32'h13, 8'h01);
      do_fetch(32'h10);
      chk("plan_word10", FetchData, 32'hABCDEF01);
      do_load(32'h80, 8'h55);
      do_load(32'hFFFF_FFFF, 8'h66);
      do_fetch(32'h10);

      // Randomized mix of loads and fetches.
      last_fa = 32'h0;
      for (int n = 0; n < 60; n++) begin
         r = $urandom_range(0, 13);
         if (r < 5)       a = {25'd0, 5'($urandom_range(0, 31)), 2'b00};
         else if (r == 5) a = {25'd0, 5'($urandom_range(0, 31)), 2'($urandom_range(1, 3))};
         else if (r == 6) a = 32'h80 + {27'd0, 3'($urandom_range(0, 7)), 2'b00};
         else if (r < 9)  a = last_fa;
         else             a = 32'($urandom_range(0, 140));
         if (r < 9) begin
            do_fetch(a);
            last_fa = a;
         end else begin
            do_load(a, 8'($urandom));
         end
      end

      // Reset in C3 of a fetch aborts it.
      chk("mid_rdy", FetchRdy, 1);
      FetchReq = 1'b1; FetchAddr = 32'h10;
      tick();
      FetchReq = 1'b0;
      tick(); tick();
      chk("mid_c3_rw", MemRW, 1);
      Reset = 1'b1;
      tick();
      chk("mid_rst_rw",    MemRW, 0);
      chk("mid_rst_valid", FetchValid, 0);
      Reset = 1'b0;
      ref_cv = 1'b0;
      for (int k = 0; k < 7; k++) begin
         tick();
         chk("mid_no_valid", FetchValid, 0);
         chk("mid_frdy",     FetchRdy, 1);
      end

      // Both requesters held continuously: grants alternate, fetch first.
      b = 8'($urandom);
      ref_mem[32] = b;
      FetchReq = 1'b1; FetchAddr = 32'h40;
      LoadReq  = 1'b1; LoadAddr  = 32'h20; LoadByte = b;
      exp_f = 1'b1; grants = 0;
      for (int cyc = 0; cyc < 60 && grants < 6; cyc++) begin
         rdy_before = FetchRdy;
         tick();
         if (rdy_before) begin
            got_f = MemRW || FetchValid;
            chk("arb_grant", got_f, exp_f);
            chk("arb_load_we", MemWE, !exp_f);
            exp_f = !exp_f;
            grants++;
         end
         chk("arb_excl", MemRW && MemWE, 0);
      end
      chk("arb_count", grants, 6);
      FetchReq = 1'b0; LoadReq = 1'b0;
      for (int k = 0; k < 8; k++) tick();
      if (ref_cv && (ref_tag[31:2] == 30'h8)) ref_cv = 1'b0;
      do_fetch(32'h20);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
`default_nettype wire
